// File: rtl/sram_pkg.sv
// sram_pkg: shared state encoding and default geometry/timing for the SRAM controller. rev 1.0
`default_nettype none

package sram_pkg;

  localparam int DEF_AW       = 18;
  localparam int DEF_DW       = 16;
  localparam int DEF_WAIT_CYC = 2;
  localparam int DEF_TURN_CYC = 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_PULSE  = 3'd2,
    ST_HOLD   = 3'd3,
    ST_TURN   = 3'd4,
    ST_VTURN  = 3'd5,
    ST_VPULSE = 3'd6,
    ST_VRSP   = 3'd7
  } state_t;

endpackage

`default_nettype wire

// File: rtl/sram_timer.sv
// sram_timer: loadable down-counter; done is high while the count is zero. rev 1.0
`default_nettype none

module sram_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

`default_nettype wire

// File: rtl/sram_ctrl.sv
// sram_ctrl: single-request async SRAM strobe sequencer; define SRAM_CTRL_VERIFY_EN for write read-back verify. rev 1.0
`default_nettype none

module sram_ctrl
  import sram_pkg::*;
#(
  parameter int AW       = DEF_AW,
  parameter int DW       = DEF_DW,
  parameter int WAIT_CYC = DEF_WAIT_CYC,
  parameter int TURN_CYC = DEF_TURN_CYC
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_dq_o,
  output logic          sram_dq_oe,
  input  logic [DW-1:0] sram_dq_i,
  output logic          sram_cs_n,
  output logic          sram_oe_n,
  output logic          sram_we_n
);

`ifdef SRAM_CTRL_VERIFY_EN
  localparam bit VERIFY = 1'b1;
`else
  localparam bit VERIFY = 1'b0;
`endif

  localparam int CNT_MAX = (WAIT_CYC > TURN_CYC) ? WAIT_CYC : TURN_CYC;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CW-1:0] WAIT_LD = CW'(WAIT_CYC - 1);
  localparam logic [CW-1:0] TURN_LD = CW'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);
  localparam state_t POST_ACC = (TURN_CYC == 0) ? ST_IDLE : ST_TURN;

  state_t        state;
  state_t        state_nxt;
  logic          accept;
  logic          we_q;
  logic          we_nxt;
  logic          timer_load;
  logic [CW-1:0] timer_val;
  logic          timer_done;
  logic          sample_rd;
  logic          cs_n_nxt;
  logic          oe_n_nxt;
  logic          we_n_nxt;
  logic          dq_oe_nxt;
  logic          rsp_nxt;

  assign accept = req_valid && req_ready;
  assign we_nxt = accept ? req_we : we_q;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (accept) state_nxt = ST_SETUP;
      ST_SETUP:  state_nxt = ST_PULSE;
      ST_PULSE:  if (timer_done) state_nxt = ST_HOLD;
      ST_HOLD: begin
`ifdef SRAM_CTRL_VERIFY_EN
        state_nxt = we_q ? ST_VTURN : POST_ACC;
`else
        state_nxt = POST_ACC;
`endif
      end
      ST_TURN:   if (timer_done) state_nxt = ST_IDLE;
`ifdef SRAM_CTRL_VERIFY_EN
      ST_VTURN:  state_nxt = ST_VPULSE;
      ST_VPULSE: if (timer_done) state_nxt = ST_VRSP;
      ST_VRSP:   state_nxt = POST_ACC;
`endif
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Pin strobes are registered from the next state so the pads never see decode glitches.
  always_comb begin
    cs_n_nxt  = 1'b1;
    oe_n_nxt  = 1'b1;
    we_n_nxt  = 1'b1;
    dq_oe_nxt = 1'b0;
    case (state_nxt)
      ST_SETUP: begin
        cs_n_nxt  = 1'b0;
        dq_oe_nxt = we_nxt;
      end
      ST_PULSE: begin
        cs_n_nxt  = 1'b0;
        we_n_nxt  = !we_nxt;
        oe_n_nxt  = we_nxt;
        dq_oe_nxt = we_nxt;
      end
      ST_HOLD: begin
        cs_n_nxt  = 1'b0;
        dq_oe_nxt = we_nxt;
      end
      ST_VTURN, ST_VRSP: cs_n_nxt = 1'b0;
      ST_VPULSE: begin
        cs_n_nxt = 1'b0;
        oe_n_nxt = 1'b0;
      end
      default: ;
    endcase
  end

  assign rsp_nxt    = ((state_nxt == ST_HOLD) && !(VERIFY && we_nxt)) || (state_nxt == ST_VRSP);
  assign timer_load = (state_nxt != state) &&
                      ((state_nxt == ST_PULSE) || (state_nxt == ST_TURN) || (state_nxt == ST_VPULSE));
  assign timer_val  = (state_nxt == ST_TURN) ? TURN_LD : WAIT_LD;
  assign sample_rd  = timer_done && (((state == ST_PULSE) && !we_q) || (state == ST_VPULSE));

  sram_timer #(
    .W(CW)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (timer_load),
    .load_val (timer_val),
    .done     (timer_done)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      req_ready  <= 1'b0;
      we_q       <= 1'b0;
      sram_addr  <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_cs_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
    end else begin
      state      <= state_nxt;
      req_ready  <= (state_nxt == ST_IDLE);
      sram_cs_n  <= cs_n_nxt;
      sram_oe_n  <= oe_n_nxt;
      sram_we_n  <= we_n_nxt;
      sram_dq_oe <= dq_oe_nxt;
      rsp_valid  <= rsp_nxt;
      if (accept) begin
        we_q      <= req_we;
        sram_addr <= req_addr;
        if (req_we) sram_dq_o <= req_wdata;
      end
      if (sample_rd) rsp_rdata <= sram_dq_i;
    end
  end

`ifdef SRAM_CTRL_VERIFY_EN
  logic err_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else if (sample_rd) begin
      err_q <= we_q && (sram_dq_i != sram_dq_o);
    end
  end

  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/sram_ctrl.md
# sram_ctrl

Synchronous controller for the external 256K×16 asynchronous SRAM, sitting between on-chip requesters (test sequencer, display data path) and the SRAM pins. It accepts one word request at a time over a valid/ready handshake and generates the CS/OE/WE strobe sequence with programmable pulse widths and bus turnaround. It returns read data or write completion as a one-cycle response pulse. Tri-state pad muxing stays in the top level, driven from `sram_dq_o`/`sram_dq_oe`.

## Interface
- `AW`, 18, address width
- `DW`, 16, data width
- `WAIT_CYC`, 2, strobe (OE/WE low) width in clk cycles; ≥1
- `TURN_CYC`, 1, idle cycles after each access with CS high and bus released; ≥0

- `clk`  in  1  system clock (100 MHz)
- `rst_n`  in  1  reset, synchronous, active-low
- `req_valid`  in  1  request present
- `req_ready`  out  1  controller idle, request accepted when both high
- `req_we`  in  1  1 = write, 0 = read
- `req_addr`  in  AW  word address
- `req_wdata`  in  DW  write data
- `rsp_valid`  out  1  one-cycle completion pulse
- `rsp_rdata`  out  DW  read data, valid with `rsp_valid`
- `rsp_err`  out  1  write-verify mismatch, valid with `rsp_valid`
- `sram_addr`  out  AW  SRAM address pins
- `sram_dq_o`  out  DW  data to pads
- `sram_dq_oe`  out  1  pad output enable
- `sram_dq_i`  in  DW  data from pads
- `sram_cs_n`, `sram_oe_n`, `sram_we_n`  out  1 each  active-low strobes

## Operation
- States: IDLE, SETUP, PULSE, HOLD, TURN (+ VTURN, VPULSE with verify).
- IDLE: `req_ready`=1, CS/OE/WE high, `sram_dq_oe`=0. Acceptance registers `req_we`, `req_addr`, `req_wdata`; later input changes ignored.
- SETUP (1 cycle): `sram_addr` driven, `sram_cs_n`=0. Write: `sram_dq_o`=wdata, `sram_dq_oe`=1.
- PULSE (`WAIT_CYC` cycles): write `sram_we_n`=0; read `sram_oe_n`=0. Read samples `sram_dq_i` into `rsp_rdata` at the edge ending the last PULSE cycle.
- HOLD (1 cycle): strobes high, CS low, write data still driven, `rsp_valid`=1.
- TURN (`TURN_CYC` cycles): CS high, `sram_dq_oe`=0. Then IDLE. When `TURN_CYC`=0, HOLD goes directly to IDLE.
- `sram_addr` and `sram_dq_o` retain their last values in IDLE.
- `sram_oe_n` and `sram_we_n` are never low together. `sram_dq_oe` is never 1 while `sram_oe_n`=0.
- Writes without verify: `rsp_rdata` unchanged, `rsp_err`=0.
- No response back-pressure. The consumer must take `rsp_valid` when it is asserted.

## Timing
- Acceptance edge = cycle 0. SETUP = cycle 1. PULSE = cycles 2..`WAIT_CYC`+1. `rsp_valid` high in cycle `WAIT_CYC`+2.
- `req_ready` returns high in cycle `WAIT_CYC`+3+`TURN_CYC`. Back-to-back period is `WAIT_CYC`+3+`TURN_CYC` cycles (6 with defaults).
- Reset values: `req_ready`=0 while `rst_n`=0, then 1 in the first cycle after release. `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, `sram_addr`=0, `sram_dq_o`=0, `sram_dq_oe`=0, CS/OE/WE=1.
- Reset mid-access aborts at the next edge. Strobes go high and the bus is released on that edge. No response is issued.
- A request presented in the same cycle as `rst_n`=0 is ignored.

## Configuration
- `SRAM_CTRL_VERIFY_EN` defined: each write continues from HOLD into VTURN. VTURN is 1 cycle with CS low, `sram_dq_oe`=0, OE high.
- VTURN is followed by VPULSE (`WAIT_CYC` cycles, `sram_oe_n`=0, sample at end). Then a response cycle with `rsp_valid`=1, `rsp_rdata`=readback, `rsp_err`=(readback≠wdata). Then TURN.
- With verify, write `rsp_valid` moves to cycle 2·`WAIT_CYC`+4, and HOLD does not pulse `rsp_valid`.
- Undefined: no verify states, `rsp_err` tied 0. Reads are identical in both builds.

## Structure
- Package `sram_pkg`: state enum, default `AW`/`DW`/`WAIT_CYC`/`TURN_CYC` constants.
- Sub-module `sram_timer`: loadable down-counter with a `done` flag, used for PULSE/TURN/VPULSE durations.
- No other hierarchy. Inout pads stay in `top`.

## Test plan
- Write 0x15C5D←0xDEAD, defaults → `sram_we_n` low cycles 2–3, `sram_dq_oe` high cycles 1–4 only, `rsp_valid` at cycle 4, `req_ready` at cycle 6.
- Read 0x3AB2D, SRAM model returns 0xBEEF → `sram_oe_n` low cycles 2–3, `rsp_rdata`=0xBEEF with `rsp_valid` at cycle 4. `sram_dq_oe` stays 0 throughout.
- `req_valid` held high for 3 back-to-back writes then 2 reads, `WAIT_CYC`=1, `TURN_CYC`=0 → one access every 4 cycles, read data matches, no OE/WE overlap (assertion).
- `rst_n` low in cycle 2 of a write → all strobes high and `sram_dq_oe`=0 on the next edge, no `rsp_valid`, `req_ready`=1 the cycle after release.
- Verify build, write 0x1234, model with stuck bit 0 → `rsp_valid` at cycle 8, `rsp_rdata`=0x1234 readback with bit 0 forced, `rsp_err`=1. A fault-free model gives `rsp_err`=0.
- `req_addr`/`req_wdata` toggled every cycle after acceptance → `sram_addr`/`sram_dq_o` stable at the accepted values until IDLE.
